// File: rtl/ula_arbiter_if.sv
// Requester and response handshake bundle for ula_arbiter.
// slave is the arbiter side, master is the requester/consumer side.
interface ula_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_flag;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_flag,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_flag,
    output rsp_ready
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin front end sharing one external ALU between two requesters.
// One op in flight: IDLE accepts, EXEC captures the ALU, RESP hands back.
module ula_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  ula_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_saida,
  input  logic             alu_flag,
  output logic [CNT_W-1:0] ovf_count
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g0, g1;

  // Tie goes to the requester that did not win last time
  always_comb begin
    g0 = bus.req0_valid && (!bus.req1_valid || last_q);
    g1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  end

  // Next-state and handshake decode
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    id_d           = id_q;
    data_d         = data_q;
    flag_d         = flag_q;
    cnt_d          = cnt_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req0_ready = g0;
        bus.req1_ready = g1;
        if (g0) begin
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          op_d    = bus.req0_op;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = EXEC;
        end else if (g1) begin
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          op_d    = bus.req1_op;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_saida;
        flag_d  = alu_flag;
        if (alu_flag && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flag  = flag_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign ovf_count     = cnt_q;
endmodule
